// File: rtl/hmc_mem_link_pkg.sv
// Shared types for the HMC-side link initialization sequencer.
// Holds the FSM state and TX-mode encodings and the error-sensitivity predicate.
package hmc_mem_link_pkg;

  localparam int STATE_W   = 4;
  localparam int TX_MODE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_RESET  = 4'd0,
    S_INIT   = 4'd1,
    S_PRBS   = 4'd2,
    S_TS1    = 4'd3,
    S_NULL   = 4'd4,
    S_TRET   = 4'd5,
    S_ACTIVE = 4'd6,
    S_SLEEP  = 4'd7,
    S_ERR    = 4'd8
  } link_state_e;

  typedef enum logic [TX_MODE_W-1:0] {
    TX_IDLE = 3'd0,
    TX_PRBS = 3'd1,
    TX_TS1  = 3'd2,
    TX_NULL = 3'd3,
    TX_TRET = 3'd4,
    TX_DATA = 3'd5
  } tx_mode_e;

  // RX errors only matter once the host link is trained far enough to report them.
  function automatic logic rx_err_armed(input link_state_e s);
    return (s == S_TS1) || (s == S_NULL) || (s == S_TRET) || (s == S_ACTIVE);
  endfunction

endpackage

// File: rtl/hmc_mem_cycle_timer.sv
// Loadable down-counter shared by all timed phases of the link sequencer.
// Saturates at zero; load takes priority over decrement.
module hmc_mem_cycle_timer #(
  parameter int CNT_W = 16
) (
  input  logic             hmc_clk,
  input  logic             hmc_res,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec_en,
  output logic             o_zero,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_cnt_nxt
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // next count: load, saturating decrement, or hold
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_load) begin
      w_cnt_nxt = i_load_val;
    end else if (i_dec_en && (r_cnt != {CNT_W{1'b0}})) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // count register
  always_ff @(posedge hmc_clk or posedge hmc_res) begin
    if (hmc_res) begin
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_zero    = (r_cnt == {CNT_W{1'b0}});
  assign o_cnt     = r_cnt;
  assign o_cnt_nxt = w_cnt_nxt;

endmodule

// File: rtl/hmc_mem_link_init_ctrl.sv
// HMC-side link power-on/initialization sequencer: reset, PRBS, TS1, NULL, TRET, active,
// sleep and fatal-error handling. Outputs are registered from the next-state decode.
module hmc_mem_link_init_ctrl
  import hmc_mem_link_pkg::*;
#(
  parameter int T_INIT_CYC  = 64,
  parameter int T_NULL_CYC  = 55,
  parameter int TRET_CNT    = 8,
  parameter int T_SLEEP_CYC = 16,
  parameter int CNT_W       = 16
) (
  input  logic         hmc_clk,
  input  logic         hmc_res,
  input  logic         P_RST_N,
  input  logic         LXRXPS,
  output logic         LXTXPS,
  output logic         FERR_N,
  input  logic         rx_ts1_locked,
  input  logic         rx_null_seen,
  input  logic         rx_error,
  input  logic         err_clr,
  input  logic         tx_ready,
  output logic [2:0]   tx_mode,
  output logic         tret_req,
  input  logic         tret_ack,
  output logic         link_up,
  output logic [3:0]   init_state
);

  link_state_e      r_state;
  link_state_e      w_state_nxt;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_dec;
  logic             w_zero;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             r_lxtxps;
  logic             r_ferr_n;
  tx_mode_e         r_tx_mode;
  logic             r_tret_req;
  logic             r_link_up;
  logic             w_lxtxps_nxt;
  logic             w_ferr_n_nxt;
  tx_mode_e         w_tx_mode_nxt;
  logic             w_tret_req_nxt;
  logic             w_link_up_nxt;

  hmc_mem_cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .hmc_clk    (hmc_clk),
    .hmc_res    (hmc_res),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec_en   (w_dec),
    .o_zero     (w_zero),
    .o_cnt      (w_cnt),
    .o_cnt_nxt  (w_cnt_nxt)
  );

  // next-state and counter control
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = {CNT_W{1'b0}};
    w_dec       = 1'b0;
    if (!P_RST_N) begin
      w_state_nxt = S_RESET;
      w_load      = 1'b1;
    end else if (rx_error && rx_err_armed(r_state)) begin
      w_state_nxt = S_ERR;
    end else begin
      case (r_state)
        S_RESET: begin
          w_state_nxt = S_INIT;
          w_load      = 1'b1;
          w_load_val  = CNT_W'(T_INIT_CYC - 1);
        end
        S_INIT: begin
          if (w_zero) begin
            w_state_nxt = S_PRBS;
          end else begin
            w_dec = 1'b1;
          end
        end
        S_PRBS: begin
          if (rx_ts1_locked) begin
            w_state_nxt = S_TS1;
          end else begin
            w_state_nxt = S_PRBS;
          end
        end
        S_TS1: begin
          if (rx_null_seen) begin
            w_state_nxt = S_NULL;
            w_load      = 1'b1;
            w_load_val  = CNT_W'(T_NULL_CYC);
          end else begin
            w_state_nxt = S_TS1;
          end
        end
        S_NULL: begin
          w_dec = tx_ready;
          if (tx_ready && (w_cnt <= CNT_W'(1))) begin
            w_state_nxt = (TRET_CNT == 0) ? S_ACTIVE : S_TRET;
            w_load      = 1'b1;
            w_load_val  = CNT_W'(TRET_CNT);
          end else begin
            w_state_nxt = S_NULL;
          end
        end
        // tret_req is high for the whole S_TRET residency, so ack alone qualifies here
        S_TRET: begin
          w_dec = tret_ack;
          if (tret_ack && (w_cnt <= CNT_W'(1))) begin
            w_state_nxt = S_ACTIVE;
          end else begin
            w_state_nxt = S_TRET;
          end
        end
        S_ACTIVE: begin
          if (!LXRXPS) begin
            w_state_nxt = S_SLEEP;
            w_load      = 1'b1;
            w_load_val  = CNT_W'(T_SLEEP_CYC);
          end else begin
            w_state_nxt = S_ACTIVE;
          end
        end
        S_SLEEP: begin
          if (LXRXPS) begin
            w_state_nxt = S_INIT;
            w_load      = 1'b1;
            w_load_val  = CNT_W'(T_INIT_CYC - 1);
          end else begin
            w_dec = 1'b1;
          end
        end
        S_ERR: begin
          if (err_clr) begin
            w_state_nxt = S_INIT;
            w_load      = 1'b1;
            w_load_val  = CNT_W'(T_INIT_CYC - 1);
          end else begin
            w_state_nxt = S_ERR;
          end
        end
        default: begin
          w_state_nxt = S_RESET;
          w_load      = 1'b1;
        end
      endcase
    end
  end

  // output decode of the state being entered, so the registers track r_state
  always_comb begin
    w_lxtxps_nxt   = 1'b1;
    w_ferr_n_nxt   = 1'b1;
    w_tx_mode_nxt  = TX_IDLE;
    w_tret_req_nxt = 1'b0;
    w_link_up_nxt  = 1'b0;
    case (w_state_nxt)
      S_RESET:  w_lxtxps_nxt   = 1'b0;
      S_INIT:   w_tx_mode_nxt  = TX_IDLE;
      S_PRBS:   w_tx_mode_nxt  = TX_PRBS;
      S_TS1:    w_tx_mode_nxt  = TX_TS1;
      S_NULL:   w_tx_mode_nxt  = TX_NULL;
      S_TRET: begin
        w_tx_mode_nxt  = TX_TRET;
        w_tret_req_nxt = 1'b1;
      end
      S_ACTIVE: begin
        w_tx_mode_nxt = TX_DATA;
        w_link_up_nxt = 1'b1;
      end
      S_SLEEP:  w_lxtxps_nxt   = (w_cnt_nxt != {CNT_W{1'b0}});
      S_ERR:    w_ferr_n_nxt   = 1'b0;
      default:  w_lxtxps_nxt   = 1'b0;
    endcase
  end

  // state and output registers
  always_ff @(posedge hmc_clk or posedge hmc_res) begin
    if (hmc_res) begin
      r_state    <= S_RESET;
      r_lxtxps   <= 1'b0;
      r_ferr_n   <= 1'b1;
      r_tx_mode  <= TX_IDLE;
      r_tret_req <= 1'b0;
      r_link_up  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lxtxps   <= w_lxtxps_nxt;
      r_ferr_n   <= w_ferr_n_nxt;
      r_tx_mode  <= w_tx_mode_nxt;
      r_tret_req <= w_tret_req_nxt;
      r_link_up  <= w_link_up_nxt;
    end
  end

  assign LXTXPS     = r_lxtxps;
  assign FERR_N     = r_ferr_n;
  assign tx_mode    = r_tx_mode;
  assign tret_req   = r_tret_req;
  assign link_up    = r_link_up;
  assign init_state = r_state;

endmodule

// File: doc/hmc_mem_link_init_ctrl.md
Name: hmc_mem_link_init_ctrl

Overview:
- HMC-side (memory model) link power-on/initialization sequencer for the HMC memory agent.
- Watches the host's P_RST_N, LXRXPS and the RX-path status flags, and drives LXTXPS and FERR_N.
- Tells the TX flit generator what to transmit (PRBS, TS1, NULL, TRET, data) and issues TRET requests through a handshake.
- Implements the tNULL/tTRET phases as cycle counts, at the hmc_clk domain.

Parameters:
- T_INIT_CYC, 64: cycles between P_RST_N release and start of PRBS transmission.
- T_NULL_CYC, 55: tx_ready-qualified cycles of NULL flits (220 ns at 4 ns clock). Must be >= 1.
- TRET_CNT, 8: number of TRET packets issued before link_up. 0 is legal (phase skipped).
- T_SLEEP_CYC, 16: cycles from LXRXPS low to LXTXPS low.
- CNT_W, 16: width of the internal down-counter. Every cycle parameter must be < 2**CNT_W.

Ports:
- hmc_clk  in  1  clock.
- hmc_res  in  1  asynchronous active-high reset.
- P_RST_N  in  1  host-driven HMC reset, active low, synchronous to hmc_clk.
- LXRXPS  in  1  host power-state request: 1 = active, 0 = sleep.
- LXTXPS  out  1  HMC power-state acknowledge.
- FERR_N  out  1  fatal error, active low.
- rx_ts1_locked  in  1  RX descrambler locked and host TS1 detected.
- rx_null_seen  in  1  RX has seen host NULL flits after TS1.
- rx_error  in  1  RX CRC/sequence error pulse.
- err_clr  in  1  clears the error state.
- tx_ready  in  1  TX generator consumed one flit group this cycle.
- tx_mode  out  3  0 IDLE, 1 PRBS, 2 TS1, 3 NULL, 4 TRET, 5 DATA.
- tret_req  out  1  request one TRET packet.
- tret_ack  in  1  TRET packet accepted.
- link_up  out  1  link in ACTIVE state.
- init_state  out  4  current FSM state encoding (debug).

Behaviour:
- Reset values (hmc_res=1, async):
  - state S_RESET, counter 0.
  - LXTXPS=0, FERR_N=1, tx_mode=IDLE, tret_req=0, link_up=0, init_state=0.
- All outputs are registered and reflect the current state; there is no combinational input-to-output path.
- States and encodings: S_RESET(0), S_INIT(1), S_PRBS(2), S_TS1(3), S_NULL(4), S_TRET(5), S_ACTIVE(6), S_SLEEP(7), S_ERR(8).
- Transition priority, applied every cycle:
  1. P_RST_N=0 goes to S_RESET next cycle from any state.
  2. rx_error=1 in S_TS1..S_ACTIVE goes to S_ERR.
  3. State-specific transitions below.
- S_RESET:
  - Outputs: LXTXPS=0, tx_mode=IDLE.
  - P_RST_N=1 goes to S_INIT and loads the counter with T_INIT_CYC-1.
- S_INIT:
  - Outputs: LXTXPS=1, tx_mode=IDLE.
  - Counter decrements every cycle; at 0 goes to S_PRBS. The phase lasts exactly T_INIT_CYC cycles.
- S_PRBS:
  - Output: tx_mode=PRBS.
  - rx_ts1_locked=1 goes to S_TS1.
- S_TS1:
  - Output: tx_mode=TS1.
  - rx_null_seen=1 goes to S_NULL and loads the counter with T_NULL_CYC.
- S_NULL:
  - Output: tx_mode=NULL.
  - Counter decrements only on cycles with tx_ready=1.
  - When a decrement reaches 0, goes to S_TRET (counter loaded with TRET_CNT), or to S_ACTIVE if TRET_CNT=0.
- S_TRET:
  - Outputs: tx_mode=TRET, tret_req=1 while the remaining count is > 0.
  - Each cycle with tret_req&tret_ack decrements the count. tret_ack without tret_req is ignored.
  - When the last ack arrives, tret_req drops the next cycle and the FSM goes to S_ACTIVE.
- S_ACTIVE:
  - Outputs: tx_mode=DATA, link_up=1.
  - LXRXPS=0 goes to S_SLEEP and loads the counter with T_SLEEP_CYC.
- S_SLEEP:
  - Outputs: tx_mode=IDLE, link_up=0.
  - LXTXPS stays 1 until the counter reaches 0, then goes 0.
  - LXRXPS=1 at any time goes to S_INIT (full re-init, LXTXPS=1).
- S_ERR:
  - Outputs: FERR_N=0, tx_mode=IDLE, link_up=0, tret_req=0.
  - err_clr=1 goes to S_INIT; FERR_N returns to 1 the next cycle.
- rx_error while in S_ERR, S_SLEEP, S_PRBS or S_INIT is ignored.
- Counter arithmetic: unsigned, CNT_W bits, never wraps. Decrement is suppressed at 0.

Decomposition:
- Package hmc_mem_link_pkg holds:
  - link_state_e enum (encodings above);
  - tx_mode_e enum;
  - TX_MODE_W=3 and STATE_W=4 constants.
- Sub-module hmc_mem_cycle_timer:
  - loadable CNT_W down-counter with load, load_val, dec_en, zero outputs;
  - async active-high reset on hmc_res.

Test Plan:
- Nominal bring-up:
  - Stimulus: release P_RST_N; after PRBS starts, assert rx_ts1_locked; after 10 cycles, assert rx_null_seen; tx_ready=1; tret_ack=1 constantly.
  - Required: LXTXPS=1 one cycle after release; PRBS exactly 64 cycles after S_INIT entry; NULL for 55 cycles; exactly 8 tret_req&ack cycles; link_up=1 on the next cycle.
- tx_ready gaps:
  - Stimulus: tx_ready toggles 1/0 in S_NULL.
  - Required: NULL lasts 110 cycles. Stimulus: tret_ack every third cycle. Required: 8 TRETs over 24 cycles, then link_up.
- Sleep/wake:
  - Stimulus: LXRXPS=0 in ACTIVE.
  - Required: link_up=0 next cycle and LXTXPS=0 after 16 cycles. Stimulus: LXRXPS=1. Required: S_INIT, LXTXPS=1, full re-sequence.
- Error:
  - Stimulus: rx_error during S_TRET.
  - Required: FERR_N=0, tret_req=0 next cycle. Stimulus: err_clr. Required: FERR_N=1 and S_INIT.
- Priority:
  - Stimulus: P_RST_N=0 and rx_error in the same cycle in ACTIVE. Required: S_RESET with FERR_N=1.
  - Stimulus: hmc_res asserted mid-S_NULL. Required: all outputs at reset values immediately (async).
- TRET_CNT=0 build:
  - Required: S_NULL goes directly to S_ACTIVE and tret_req never asserts.
